// File: rtl/sd_dev_platform_gen.sv
// -----------------------------------------------------------------------------
// sd_dev_platform_gen
// SD host platform glue: programmable SD clock divider with edge strobes,
// a post-reset lock delay, and registered tri-state CMD/DAT pin drivers with
// turnaround and 2-flop input synchronisers.
//
// Optional build macro: SD_DEV_PLATFORM_LOOPBACK_EN adds i_loopback, which
// releases all pins and feeds the registered output values into the
// synchronisers instead of the pins.
//
// Ports
//   clk, rst_n            block clock, async active-low reset
//   i_clk_div             SD clock half-period in clk cycles, minus 1
//   i_clk_en              1 = SD clock runs, 0 = SD clock holds its level
//   o_locked              platform ready (LOCK_CYCLES after reset release)
//   o_out_clk, o_phy_clk  divided SD clock (stack copy, pin copy)
//   o_clk_rise/_fall      single-cycle strobes on SD clock edges
//   i_sd_cmd_dir/_out     CMD drive enable / value; o_sd_cmd_in synchronised pin
//   i_sd_data_dir/_out    DAT drive enable / value; o_sd_data_in synchronised pins
//   io_phy_sd_cmd/_data   SD bus pins
// -----------------------------------------------------------------------------

// One pin group: registered value, output enable with turnaround, synchroniser.
module sd_dev_platform_gen_path #(
    parameter int unsigned W           = 1,
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_locked,
    input  logic         i_dir,
    input  logic [W-1:0] i_out,
    input  logic [W-1:0] i_pin,
    output logic         o_oe,
    output logic [W-1:0] o_val,
    output logic [W-1:0] o_sync
);
    localparam int unsigned TURN_W = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;

    logic [TURN_W-1:0] r_turn;
    logic              r_oe;
    logic [W-1:0]      r_val;
    logic [W-1:0]      r_meta;
    logic [W-1:0]      r_sync;

    // Enable only after the dir has been held for TURN_CYCLES extra cycles;
    // any dir drop clears the turnaround so a re-request starts over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oe   <= 1'b0;
            r_turn <= '0;
            r_val  <= '0;
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_val  <= i_out;
            r_meta <= i_pin;
            r_sync <= r_meta;
            if (!i_locked || !i_dir) begin
                r_oe   <= 1'b0;
                r_turn <= '0;
            end else if (!r_oe) begin
                if (r_turn == TURN_W'(TURN_CYCLES)) begin
                    r_oe <= 1'b1;
                end else begin
                    r_turn <= r_turn + TURN_W'(1);
                end
            end
        end
    end

    assign o_oe   = r_oe;
    assign o_val  = r_val;
    assign o_sync = r_sync;
endmodule

module sd_dev_platform_gen #(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned LOCK_CYCLES = 16,
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  i_clk_div,
    input  logic              i_clk_en,
`ifdef SD_DEV_PLATFORM_LOOPBACK_EN
    input  logic              i_loopback,
`endif
    output logic              o_locked,
    output logic              o_out_clk,
    output logic              o_phy_clk,
    output logic              o_clk_rise,
    output logic              o_clk_fall,
    input  logic              i_sd_cmd_dir,
    input  logic              i_sd_cmd_out,
    output logic              o_sd_cmd_in,
    input  logic              i_sd_data_dir,
    input  logic [DATA_W-1:0] i_sd_data_out,
    output logic [DATA_W-1:0] o_sd_data_in,
    inout  wire               io_phy_sd_cmd,
    inout  wire  [DATA_W-1:0] io_phy_sd_data
);
    localparam int unsigned LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;

    logic [LOCK_W-1:0] r_lock_cnt;
    logic              r_locked;
    logic [DIV_W-1:0]  r_div_cnt;
    logic              r_out_clk;
    logic              r_clk_rise;
    logic              r_clk_fall;

    logic              w_lb;
    logic              w_cmd_oe;
    logic              w_cmd_val;
    logic              w_cmd_smp;
    logic              w_dat_oe;
    logic [DATA_W-1:0] w_dat_val;
    logic [DATA_W-1:0] w_dat_smp;

`ifdef SD_DEV_PLATFORM_LOOPBACK_EN
    assign w_lb = i_loopback;
`else
    assign w_lb = 1'b0;
`endif

    // Lock delay: counts from reset release, sticky once set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (!r_locked) begin
            if (r_lock_cnt >= LOCK_W'(LOCK_CYCLES - 1)) begin
                r_locked <= 1'b1;
            end else begin
                r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
            end
        end
    end

    // SD clock divider; >= compare so a lowered divide never waits for a wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt  <= '0;
            r_out_clk  <= 1'b0;
            r_clk_rise <= 1'b0;
            r_clk_fall <= 1'b0;
        end else begin
            r_clk_rise <= 1'b0;
            r_clk_fall <= 1'b0;
            if (r_locked && i_clk_en) begin
                if (r_div_cnt >= i_clk_div) begin
                    r_div_cnt  <= '0;
                    r_out_clk  <= ~r_out_clk;
                    r_clk_rise <= ~r_out_clk;
                    r_clk_fall <= r_out_clk;
                end else begin
                    r_div_cnt <= r_div_cnt + DIV_W'(1);
                end
            end
        end
    end

    sd_dev_platform_gen_path #(.W(1), .TURN_CYCLES(TURN_CYCLES)) u_cmd (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_locked (r_locked),
        .i_dir    (i_sd_cmd_dir),
        .i_out    (i_sd_cmd_out),
        .i_pin    (w_cmd_smp),
        .o_oe     (w_cmd_oe),
        .o_val    (w_cmd_val),
        .o_sync   (o_sd_cmd_in)
    );

    sd_dev_platform_gen_path #(.W(DATA_W), .TURN_CYCLES(TURN_CYCLES)) u_dat (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_locked (r_locked),
        .i_dir    (i_sd_data_dir),
        .i_out    (i_sd_data_out),
        .i_pin    (w_dat_smp),
        .o_oe     (w_dat_oe),
        .o_val    (w_dat_val),
        .o_sync   (o_sd_data_in)
    );

    // Loopback releases the pins and samples the registered drive values.
    assign io_phy_sd_cmd  = (w_cmd_oe && !w_lb) ? w_cmd_val : 1'bz;
    assign io_phy_sd_data = (w_dat_oe && !w_lb) ? w_dat_val : {DATA_W{1'bz}};
    assign w_cmd_smp      = w_lb ? w_cmd_val : io_phy_sd_cmd;
    assign w_dat_smp      = w_lb ? w_dat_val : io_phy_sd_data;

    assign o_locked   = r_locked;
    assign o_out_clk  = r_out_clk;
    assign o_phy_clk  = r_out_clk;
    assign o_clk_rise = r_clk_rise;
    assign o_clk_fall = r_clk_fall;
endmodule

// File: tb/tb_sd_dev_platform_gen.sv
// -----------------------------------------------------------------------------
// tb_sd_dev_platform_gen
// Directed sequence with randomised stimulus, checked each cycle against a
// behavioural model: SD clock half-period = i_clk_div+1 enabled cycles, lock
// after LOCK_CYCLES edges, a pin drives once its dir has been high for
// 1+TURN_CYCLES locked edges, synchronised inputs lag the pin by two edges.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sd_dev_platform_gen;
    localparam int unsigned DATA_W      = 4;
    localparam int unsigned DIV_W       = 8;
    localparam int unsigned LOCK_CYCLES = 16;
    localparam int unsigned TURN_CYCLES = 1;
    localparam int          LOCK_I      = LOCK_CYCLES;
    localparam int          TURN_I      = TURN_CYCLES;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [DIV_W-1:0]  clk_div = '0;
    logic              clk_en = 1'b0;
    logic              cmd_dir = 1'b0;
    logic              cmd_out = 1'b0;
    logic              data_dir = 1'b0;
    logic [DATA_W-1:0] data_out = '0;
    logic              lb = 1'b0;

    logic              tb_cmd_en = 1'b0;
    logic              tb_cmd_val = 1'b0;
    logic              tb_dat_en = 1'b0;
    logic [DATA_W-1:0] tb_dat_val = '0;

    logic              locked, out_clk, phy_clk, rise, fall, cmd_in;
    logic [DATA_W-1:0] dat_in;
    wire               io_cmd;
    wire  [DATA_W-1:0] io_dat;

    assign io_cmd = tb_cmd_en ? tb_cmd_val : 1'bz;
    assign io_dat = tb_dat_en ? tb_dat_val : {DATA_W{1'bz}};
    wire cmd_is_z = (io_cmd === 1'bz);
    wire dat_is_z = (io_dat === {DATA_W{1'bz}});

    sd_dev_platform_gen #(
        .DATA_W(DATA_W), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK_CYCLES), .TURN_CYCLES(TURN_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clk_div     (clk_div),
        .i_clk_en      (clk_en),
`ifdef SD_DEV_PLATFORM_LOOPBACK_EN
        .i_loopback    (lb),
`endif
        .o_locked      (locked),
        .o_out_clk     (out_clk),
        .o_phy_clk     (phy_clk),
        .o_clk_rise    (rise),
        .o_clk_fall    (fall),
        .i_sd_cmd_dir  (cmd_dir),
        .i_sd_cmd_out  (cmd_out),
        .o_sd_cmd_in   (cmd_in),
        .i_sd_data_dir (data_dir),
        .i_sd_data_out (data_out),
        .o_sd_data_in  (dat_in),
        .io_phy_sd_cmd (io_cmd),
        .io_phy_sd_data(io_dat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state
    int                m_edges, m_elapsed, m_cmd_run, m_dat_run;
    bit                m_locked, m_clk, last_tog;
    logic              m_cmd_val;
    logic [DATA_W-1:0] m_dat_val;
    logic              pa_cmd;
    bit                pa_cmd_k;
    logic [DATA_W-1:0] pa_dat;
    bit                pa_dat_k;

    // stimulus policy
    bit rnd = 1'b0;
    bit tb_zero = 1'b0;
    int en_pct = 100;
    int tb_pct = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_edges   = 0;
        m_elapsed = 0;
        m_cmd_run = 0;
        m_dat_run = 0;
        m_locked  = 1'b0;
        m_clk     = 1'b0;
        last_tog  = 1'b0;
        m_cmd_val = 1'b0;
        m_dat_val = '0;
        pa_cmd    = 1'b0;
        pa_cmd_k  = 1'b1;
        pa_dat    = '0;
        pa_dat_k  = 1'b1;
    endtask

    // Called just after a falling edge; covers one rising edge and checks after it.
    task automatic step();
        logic              c_en, c_cdir, c_cout, c_ddir, lock_b;
        logic [DIV_W-1:0]  c_div;
        logic [DATA_W-1:0] c_dout;
        bit                cdrv_now, cdrv_next, ddrv_now, ddrv_next, tog;
        logic              p_cmd;
        bit                p_cmd_k;
        logic [DATA_W-1:0] p_dat;
        bit                p_dat_k;
        int                nxt;

        c_en = clk_en; c_div = clk_div; c_cdir = cmd_dir; c_cout = cmd_out;
        c_ddir = data_dir; c_dout = data_out;

        // external drivers only where the block drives neither now nor next cycle
        cdrv_now  = (m_cmd_run >= TURN_I + 1) && !lb;
        nxt       = (c_cdir && m_locked) ? m_cmd_run + 1 : 0;
        cdrv_next = (nxt >= TURN_I + 1) && !lb;
        ddrv_now  = (m_dat_run >= TURN_I + 1) && !lb;
        nxt       = (c_ddir && m_locked) ? m_dat_run + 1 : 0;
        ddrv_next = (nxt >= TURN_I + 1) && !lb;
        if (!cdrv_now && !cdrv_next && (int'($urandom_range(99)) < tb_pct)) begin
            tb_cmd_en  = 1'b1;
            tb_cmd_val = tb_zero ? 1'b0 : 1'($urandom_range(1));
        end else begin
            tb_cmd_en  = 1'b0;
        end
        if (!ddrv_now && !ddrv_next && (int'($urandom_range(99)) < tb_pct)) begin
            tb_dat_en  = 1'b1;
            tb_dat_val = tb_zero ? '0 : DATA_W'($urandom);
        end else begin
            tb_dat_en  = 1'b0;
        end

        // value the synchronisers sample at the coming edge
        p_cmd_k = 1'b1; p_dat_k = 1'b1;
        if (lb || cdrv_now) p_cmd = m_cmd_val;
        else if (tb_cmd_en) p_cmd = tb_cmd_val;
        else begin p_cmd = 1'b0; p_cmd_k = 1'b0; end
        if (lb || ddrv_now) p_dat = m_dat_val;
        else if (tb_dat_en) p_dat = tb_dat_val;
        else begin p_dat = '0; p_dat_k = 1'b0; end

        @(negedge clk);

        lock_b = m_locked;
        if (m_edges < LOCK_I) m_edges++;
        m_locked = (m_edges >= LOCK_I);
        tog = 1'b0;
        if (lock_b && c_en) begin
            m_elapsed++;
            if (m_elapsed >= int'(c_div) + 1) begin
                tog       = 1'b1;
                m_clk     = !m_clk;
                m_elapsed = 0;
            end
        end
        last_tog  = tog;
        m_cmd_run = (c_cdir && lock_b) ? m_cmd_run + 1 : 0;
        m_dat_run = (c_ddir && lock_b) ? m_dat_run + 1 : 0;
        m_cmd_val = c_cout;
        m_dat_val = c_dout;

        chk("locked", 32'(locked), 32'(m_locked));
        chk("out_clk", 32'(out_clk), 32'(m_clk));
        chk("phy_clk", 32'(phy_clk), 32'(m_clk));
        chk("clk_rise", 32'(rise), 32'(tog && m_clk));
        chk("clk_fall", 32'(fall), 32'(tog && !m_clk));

        if ((m_cmd_run >= TURN_I + 1) && !lb) chk("cmd_pin", 32'(io_cmd), 32'(m_cmd_val));
        else if (tb_cmd_en)                   chk("cmd_pin_ext", 32'(io_cmd), 32'(tb_cmd_val));
        else                                  chk("cmd_pin_z", 32'(cmd_is_z), 32'd1);
        if ((m_dat_run >= TURN_I + 1) && !lb) chk("dat_pin", 32'(io_dat), 32'(m_dat_val));
        else if (tb_dat_en)                   chk("dat_pin_ext", 32'(io_dat), 32'(tb_dat_val));
        else                                  chk("dat_pin_z", 32'(dat_is_z), 32'd1);

        if (pa_cmd_k) chk("cmd_sync", 32'(cmd_in), 32'(pa_cmd));
        if (pa_dat_k) chk("dat_sync", 32'(dat_in), 32'(pa_dat));
        pa_cmd = p_cmd; pa_cmd_k = p_cmd_k;
        pa_dat = p_dat; pa_dat_k = p_dat_k;

        rise_cnt += int'(rise);
        fall_cnt += int'(fall);

        if (rnd) begin
            clk_en   = (int'($urandom_range(99)) < en_pct);
            cmd_out  = 1'($urandom_range(1));
            data_out = DATA_W'($urandom);
            if ($urandom_range(4) == 0) cmd_dir  = !cmd_dir;
            if ($urandom_range(4) == 0) data_dir = !data_dir;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_locked"},  32'(locked),   32'd0);
        chk({tag, "_out_clk"}, 32'(out_clk),  32'd0);
        chk({tag, "_phy_clk"}, 32'(phy_clk),  32'd0);
        chk({tag, "_rise"},    32'(rise),     32'd0);
        chk({tag, "_fall"},    32'(fall),     32'd0);
        chk({tag, "_cmd_z"},   32'(cmd_is_z), 32'd1);
        chk({tag, "_dat_z"},   32'(dat_is_z), 32'd1);
        chk({tag, "_cmd_in"},  32'(cmd_in),   32'd0);
        chk({tag, "_dat_in"},  32'(dat_in),   32'd0);
    endtask

    task automatic wait_rise(input string tag);
        int n = 0;
        while (!rise && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(rise), 32'd1);
    endtask

    initial begin
        logic prev;
        reset_model();

        // power-on reset, then lock with dirs already requesting the pins
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("por");
        @(negedge clk);
        #1 rst_n = 1'b1;
        reset_model();
        clk_div = '0; clk_en = 1'b1; cmd_dir = 1'b1; data_dir = 1'b1;
        cmd_out = 1'b1; data_out = 4'h5; tb_pct = 0;
        for (int i = 1; i <= LOCK_I; i++) begin
            step();
            if (i == LOCK_I - 1) chk("locked_before", 32'(locked), 32'd0);
            if (i == LOCK_I)     chk("locked_at_lock", 32'(locked), 32'd1);
        end
        for (int i = 0; i < 4; i++) step();
        cmd_dir = 1'b0; data_dir = 1'b0;
        for (int i = 0; i < 2; i++) step();

        // divide by 3: one rise and one fall per 8-cycle period
        clk_div = 8'd3; tb_pct = 60;
        wait_rise("div3_first_rise");
        rise_cnt = 0; fall_cnt = 0;
        for (int i = 0; i < 8; i++) step();
        chk("div3_rises", 32'(rise_cnt), 32'd1);
        chk("div3_falls", 32'(fall_cnt), 32'd1);

        // lower divide from 5 to 2 at count 4
        clk_div = 8'd5;
        wait_rise("div5_rise");
        for (int i = 0; i < 4; i++) step();
        clk_div = 8'd2;
        prev = out_clk;
        step();
        chk("div_lower_toggle", 32'(out_clk), 32'(!prev));
        prev = out_clk;
        step(); step();
        chk("div2_hold", 32'(out_clk), 32'(prev));
        step();
        chk("div2_toggle", 32'(out_clk), 32'(!prev));

        // randomised traffic with clock stalls and divide changes
        rnd = 1'b1; en_pct = 70; tb_pct = 60;
        for (int b = 0; b < 8; b++) begin
            clk_div = DIV_W'($urandom_range(6));
            for (int i = 0; i < 40; i++) step();
        end
        rnd = 1'b0; clk_en = 1'b1;

        // DAT turnaround: high-Z for two cycles, then 4'hA, synchronised 2 later
        cmd_dir = 1'b0; data_dir = 1'b0; tb_pct = 0;
        for (int i = 0; i < 3; i++) step();
        data_out = 4'hA; data_dir = 1'b1;
        step();
        chk("dat_turn_z", 32'(dat_is_z), 32'd1);
        step();
        chk("dat_drive_a", 32'(io_dat), 32'hA);
        step(); step();
        chk("dat_sync_a", 32'(dat_in), 32'hA);

        // turnaround aborted by a dir drop never drives
        data_dir = 1'b0; step(); step();
        data_dir = 1'b1; step();
        data_dir = 1'b0; step();
        chk("abort_z0", 32'(dat_is_z), 32'd1);
        step();
        chk("abort_z1", 32'(dat_is_z), 32'd1);
        data_dir = 1'b1; step();
        chk("restart_z", 32'(dat_is_z), 32'd1);
        step();
        chk("restart_drive", 32'(dat_is_z), 32'd0);
        data_dir = 1'b0; step();

        // async reset while CMD drives 0 releases the pin with no clock edge
        cmd_dir = 1'b1; cmd_out = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("cmd_drive0_en", 32'(cmd_is_z), 32'd0);
        chk("cmd_drive0_val", 32'(io_cmd), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async");
        @(negedge clk);
        #1 rst_n = 1'b1;
        reset_model();
        cmd_dir = 1'b0; data_dir = 1'b0; tb_cmd_en = 1'b0; tb_dat_en = 1'b0;
        for (int i = 0; i < LOCK_I + 2; i++) step();
        rnd = 1'b1; en_pct = 80; tb_pct = 50; clk_div = 8'd1;
        for (int i = 0; i < 60; i++) step();
        rnd = 1'b0;

`ifdef SD_DEV_PLATFORM_LOOPBACK_EN
        // loopback: pin pulled to 0 externally, block must read its own 1
        lb = 1'b1; cmd_dir = 1'b1; cmd_out = 1'b1; tb_pct = 100; tb_zero = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("lb_cmd_in", 32'(cmd_in), 32'd1);
        chk("lb_cmd_pin", 32'(io_cmd), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sd_dev_platform_gen.md
SD_DEV_PLATFORM_GEN -- requirements
Module: sd_dev_platform_gen

Interface
REQ-001 Parameter DATA_W, default 4, meaning SD data lane count; legal values 1, 4, 8.
REQ-002 Parameter DIV_W, default 8, meaning width of the clock-divide input.
REQ-003 Parameter LOCK_CYCLES, default 16, meaning clk cycles after reset release before o_locked asserts.
REQ-004 Parameter TURN_CYCLES, default 1, meaning high-Z cycles inserted before the block drives a pin it previously released.
REQ-005 clk  in  1  single block clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 i_clk_div  in  DIV_W  SD clock half-period in clk cycles, minus 1.
REQ-008 i_clk_en  in  1  1 = SD clock runs; 0 = SD clock stalls at its current level.
REQ-009 o_locked  out  1  platform ready.
REQ-010 o_out_clk  out  1  divided SD clock to the stack; o_phy_clk  out  1  identical copy driven to the pin.
REQ-011 o_clk_rise / o_clk_fall  out  1 each  single-cycle strobes marking SD clock edges.
REQ-012 i_sd_cmd_dir  in  1  1 = drive CMD; i_sd_cmd_out  in  1  CMD value; o_sd_cmd_in  out  1  synchronised CMD pin.
REQ-013 i_sd_data_dir  in  1  1 = drive DAT; i_sd_data_out  in  DATA_W; o_sd_data_in  out  DATA_W  synchronised DAT pins.
REQ-014 io_phy_sd_cmd  inout  1; io_phy_sd_data  inout  DATA_W  SD bus pins.

Function
REQ-015 Divider counter SHALL increment each clk while i_clk_en=1 and o_locked=1; when count >= i_clk_div, o_out_clk SHALL toggle and count SHALL clear to 0.
REQ-016 i_clk_div=0 SHALL yield o_out_clk = clk/2; i_clk_div=N SHALL yield period 2*(N+1) clk cycles.
REQ-017 Lowering i_clk_div below the current count SHALL cause a toggle on the next enabled cycle (>= compare); there SHALL be no wrap-around stall.
REQ-018 i_clk_en=0 SHALL hold both counter and o_out_clk; resuming SHALL continue from the held count.
REQ-019 o_clk_rise (o_clk_fall) SHALL be high exactly in the first cycle in which o_out_clk is 1 (0) after a toggle; both SHALL never be high together.
REQ-020 Lock counter SHALL count from reset release; o_locked SHALL assert after LOCK_CYCLES cycles and stay set until reset.
REQ-021 While o_locked=0, all pins SHALL be high-Z and o_out_clk SHALL be 0.
REQ-022 Pin output values SHALL be registered: 1 cycle from i_sd_*_out to pin.
REQ-023 Dir 1->0 SHALL release the pin (high-Z) 1 cycle later.
REQ-024 Dir 0->1 SHALL drive the pin 1+TURN_CYCLES cycles later; a dir drop during the turnaround SHALL abort it without ever driving.
REQ-025 CMD and DAT paths SHALL have independent output-enable and turnaround state.
REQ-026 o_sd_cmd_in / o_sd_data_in SHALL be the pin values through a 2-flop synchroniser (2-cycle latency), including while the block drives.

Reset
REQ-027 rst_n=0 SHALL asynchronously force: o_out_clk=0, o_phy_clk=0, o_clk_rise=0, o_clk_fall=0, o_locked=0, all output enables 0 (pins high-Z), synchronisers 0, all counters 0.
REQ-028 Reset asserted mid-transfer SHALL release the pins in the same instant, with no clk required.

Configuration
REQ-029 Macro SD_DEV_PLATFORM_LOOPBACK_EN defined: the block SHALL add input i_loopback (1 bit); when i_loopback=1, all pins SHALL be high-Z and the synchroniser inputs SHALL take the registered output values instead of the pins.
REQ-030 Macro undefined: i_loopback SHALL not exist and the synchronisers SHALL always sample the pins.

Verification
REQ-031 Reset release, LOCK_CYCLES=16 -> o_locked rises on cycle 16; pins high-Z and o_out_clk=0 before that.
REQ-032 i_clk_div=3, i_clk_en=1 -> o_out_clk period 8 clk cycles; one o_clk_rise and one o_clk_fall per period.
REQ-033 i_clk_div=5, then at count 4 set i_clk_div=2 -> toggle on the next cycle, then period 6 cycles.
REQ-034 i_sd_data_dir 0->1 with TURN_CYCLES=1, i_sd_data_out=4'hA -> pins high-Z for 2 cycles, 4'hA on the 2nd cycle after dir; o_sd_data_in=4'hA 2 cycles later.
REQ-035 Drive CMD=0, assert rst_n=0 between clk edges -> io_phy_sd_cmd high-Z immediately.
REQ-036 LOOPBACK_EN build, i_loopback=1, i_sd_cmd_dir=1, i_sd_cmd_out=1, pin pulled to 0 externally -> o_sd_cmd_in=1, pin not driven.
